// File: rtl/clk_div_mon_pkg.sv
// clk_div_mon_pkg: shared types and helpers for the divided-clock monitor.
package clk_div_mon_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } mon_state_t;

    // Width of the match counter: must hold values 0..lock_cnt.
    function automatic int mcnt_width(input int lock_cnt);
        int w;
        w = $clog2(lock_cnt + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/clk_div_mon_edge.sv
// clk_div_mon_edge: optional input synchroniser and rising-edge detector.
// With CLK_DIV_MON_SYNC_IN_EN defined, div_in passes through a 2-flop
// synchroniser first (two extra cycles of latency); otherwise div_in
// must already be glitch-free and synchronous to clk.
module clk_div_mon_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic div_in,
    output logic div_s,
    output logic rise
);

    logic div_prev;

`ifdef CLK_DIV_MON_SYNC_IN_EN
    logic sync1;
    logic sync2;

    // Two-stage synchroniser for an asynchronous divided clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= div_in;
            sync2 <= sync1;
        end
    end

    assign div_s = sync2;
`else
    assign div_s = div_in;
`endif

    // Previous sample of the (possibly synchronised) input for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div_prev <= 1'b0;
        else        div_prev <= div_s;
    end

    assign rise = div_s & ~div_prev;

endmodule

// File: rtl/clk_div_monitor.sv
// clk_div_monitor: measures period and high time of a divided clock in
// clk cycles, declares lock after LOCK_CNT matching periods and flags
// period, duty and activity-loss errors.
// Optional build macro: CLK_DIV_MON_SYNC_IN_EN (input synchroniser).
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for first rise; that period is partial, not measured
//   ACQ    | measuring, counting consecutive matching periods in mcnt
//   LOCKED | LOCK_CNT consecutive matches seen; locked asserted
module clk_div_monitor
    import clk_div_mon_pkg::*;
#(
    parameter int DIV_N       = 3,
    parameter int EXP_HIGH    = 2,
    parameter int CW          = 8,
    parameter int LOCK_CNT    = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          div_in,
    input  logic          clr,
    output logic [CW-1:0] meas_period,
    output logic [CW-1:0] meas_high,
    output logic          meas_valid,
    output logic          locked,
    output logic          err_period,
    output logic          err_duty,
    output logic          timeout
);

    localparam int            MW        = mcnt_width(LOCK_CNT);
    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [CW-1:0] DIV_N_C   = CW'(DIV_N);
    localparam logic [CW-1:0] EXP_HI_C  = CW'(EXP_HIGH);
    localparam logic [CW-1:0] TMO_C     = CW'(TIMEOUT_CYC);
    localparam logic [MW-1:0] LOCK_C    = MW'(LOCK_CNT);

    logic          div_s;
    logic          rise;
    logic [CW-1:0] pcnt;
    logic [CW-1:0] hcnt;
    logic [MW-1:0] mcnt;
    logic [MW-1:0] mcnt_nxt;
    mon_state_t    state;
    mon_state_t    state_nxt;
    logic          match;
    logic          tmo_hit;
    logic          mv_nxt;
    logic          ep_nxt;
    logic          ed_nxt;
    logic          to_nxt;

    clk_div_mon_edge u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .div_in (div_in),
        .div_s  (div_s),
        .rise   (rise)
    );

    assign match   = (pcnt == DIV_N_C) && (hcnt == EXP_HI_C);
    assign tmo_hit = (pcnt == TMO_C) && !rise;

    // Period and high-time counters, restarted on every rise, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
            hcnt <= '0;
        end else if (clr) begin
            pcnt <= '0;
            hcnt <= '0;
        end else if (rise) begin
            pcnt <= CW'(1);
            hcnt <= CW'(1);
        end else begin
            if (pcnt != CNT_MAX)          pcnt <= pcnt + 1'b1;
            if (div_s && hcnt != CNT_MAX) hcnt <= hcnt + 1'b1;
        end
    end

    // Next-state, match counter and pulse decode; clr overrides everything.
    always_comb begin
        state_nxt = state;
        mcnt_nxt  = mcnt;
        mv_nxt    = 1'b0;
        ep_nxt    = 1'b0;
        ed_nxt    = 1'b0;
        to_nxt    = 1'b0;
        if (clr) begin
            state_nxt = IDLE;
            mcnt_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) state_nxt = ACQ;
                end
                ACQ, LOCKED: begin
                    if (rise) begin
                        mv_nxt = 1'b1;
                        if (match) begin
                            if (state == ACQ) begin
                                mcnt_nxt = mcnt + 1'b1;
                                if (mcnt + 1'b1 == LOCK_C) state_nxt = LOCKED;
                            end
                        end else begin
                            ep_nxt    = (pcnt != DIV_N_C);
                            ed_nxt    = (pcnt == DIV_N_C);
                            state_nxt = ACQ;
                            mcnt_nxt  = '0;
                        end
                    end else if (tmo_hit) begin
                        to_nxt    = 1'b1;
                        state_nxt = IDLE;
                        mcnt_nxt  = '0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    mcnt_nxt  = '0;
                end
            endcase
        end
    end

    // State, match counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mcnt        <= '0;
            meas_period <= '0;
            meas_high   <= '0;
            meas_valid  <= 1'b0;
            locked      <= 1'b0;
            err_period  <= 1'b0;
            err_duty    <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state      <= state_nxt;
            mcnt       <= mcnt_nxt;
            meas_valid <= mv_nxt;
            locked     <= (state_nxt == LOCKED);
            err_period <= ep_nxt;
            err_duty   <= ed_nxt;
            timeout    <= to_nxt;
            if (mv_nxt) begin
                meas_period <= pcnt;
                meas_high   <= hcnt;
            end
        end
    end

endmodule

// File: tb/tb_clk_div_monitor.sv
// tb_clk_div_monitor: self-checking bench for clk_div_monitor.
// Builds with or without CLK_DIV_MON_SYNC_IN_EN.
module tb_clk_div_monitor;

    localparam int DIV_N    = 3;
    localparam int EXP_HIGH = 2;
    localparam int CW       = 8;
    localparam int LOCK_CNT = 4;
    localparam int TMO      = 64;
`ifdef CLK_DIV_MON_SYNC_IN_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          div_in = 1'b0;
    logic          clr = 1'b0;
    logic [CW-1:0] meas_period;
    logic [CW-1:0] meas_high;
    logic          meas_valid;
    logic          locked;
    logic          err_period;
    logic          err_duty;
    logic          timeout;

    always #5 clk = ~clk;

    clk_div_monitor #(
        .DIV_N(DIV_N), .EXP_HIGH(EXP_HIGH), .CW(CW),
        .LOCK_CNT(LOCK_CNT), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .div_in(div_in), .clr(clr),
        .meas_period(meas_period), .meas_high(meas_high),
        .meas_valid(meas_valid), .locked(locked),
        .err_period(err_period), .err_duty(err_duty), .timeout(timeout)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: tracks time of last rise and high cycles since it.
    int cyc = 0;
    bit m_prev, m_h1, m_h2;
    int m_mode;          // 0 idle, 1 acquiring, 2 locked
    int m_good;
    int m_last_rise;
    int m_highs;
    int e_mp, e_mh;
    bit e_mv, e_lk, e_ep, e_ed, e_to;

    // Observed pulse statistics for scenario checks.
    int n_mv, n_ep, n_ed, n_to, last_mp, last_mh, t_to;

    typedef struct {
        bit d;
        bit mv;
        bit lk;
        int mp;
        int mh;
    } vec_t;
    vec_t tbl[24];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_prev = 0; m_h1 = 0; m_h2 = 0;
        m_mode = 0; m_good = 0; m_last_rise = 0; m_highs = 0;
        e_mp = 0; e_mh = 0;
        e_mv = 0; e_lk = 0; e_ep = 0; e_ed = 0; e_to = 0;
    endtask

    task automatic model_step(input bit d, input bit c);
        bit s, r;
        int per, hi;
`ifdef CLK_DIV_MON_SYNC_IN_EN
        s = m_h2; m_h2 = m_h1; m_h1 = d;
`else
        s = d;
`endif
        r = s & ~m_prev;
        m_prev = s;
        e_mv = 0; e_ep = 0; e_ed = 0; e_to = 0;
        if (c) begin
            m_mode = 0; m_good = 0;
        end else if (r) begin
            if (m_mode != 0) begin
                per = (cyc - m_last_rise > 255) ? 255 : cyc - m_last_rise;
                hi  = (m_highs > 255) ? 255 : m_highs;
                e_mp = per; e_mh = hi; e_mv = 1;
                if (per == DIV_N && hi == EXP_HIGH) begin
                    m_good++;
                    if (m_good >= LOCK_CNT) m_mode = 2;
                end else begin
                    if (per != DIV_N) e_ep = 1; else e_ed = 1;
                    m_mode = 1; m_good = 0;
                end
            end else begin
                m_mode = 1;
            end
            m_last_rise = cyc;
            m_highs = 1;
        end else begin
            if (s) m_highs++;
            if (m_mode != 0 && cyc - m_last_rise >= TMO) begin
                e_to = 1; m_mode = 0; m_good = 0;
            end
        end
        e_lk = (m_mode == 2);
    endtask

    task automatic clear_stats();
        n_mv = 0; n_ep = 0; n_ed = 0; n_to = 0; t_to = -1;
    endtask

    // One clock: drive, wait for edge, sample 1 ns later, compare to model.
    task automatic step(input bit d, input bit c);
        logic [22:0] act, exp;
        div_in = d; clr = c;
        @(posedge clk); #1;
        model_step(d, c);
        act = {meas_period, meas_high, meas_valid, locked, err_period, err_duty, timeout};
        exp = {CW'(e_mp), CW'(e_mh), e_mv, e_lk, e_ep, e_ed, e_to};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL cycle %0d outputs {mp,mh,mv,lk,ep,ed,to}: got %h expected %h", cyc, act, exp);
        end
        if (meas_valid) begin n_mv++; last_mp = int'(meas_period); last_mh = int'(meas_high); end
        if (err_period) n_ep++;
        if (err_duty)   n_ed++;
        if (timeout) begin n_to++; t_to = cyc; end
        cyc++;
    endtask

    task automatic period(input int p, input int h);
        for (int k = 0; k < p; k++) step(k < h, 1'b0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, " meas_period"}, int'(meas_period), 0);
        check({name, " meas_high"},   int'(meas_high), 0);
        check({name, " meas_valid"},  int'(meas_valid), 0);
        check({name, " locked"},      int'(locked), 0);
        check({name, " err_period"},  int'(err_period), 0);
        check({name, " err_duty"},    int'(err_duty), 0);
        check({name, " timeout"},     int'(timeout), 0);
    endtask

    initial begin
        int r0, pr, hr, ci, rr;
        model_reset();
        clear_stats();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // Table: 1,1,0 pattern from reset; expectations from the spec rules.
        for (int i = 0; i < 24; i++) begin
            int j;
            j = i - LAT;
            tbl[i].d  = (i % 3) != 2;
            tbl[i].mv = (j >= 3) && (j % 3 == 0);
            tbl[i].lk = (j >= 12);
            tbl[i].mp = (j >= 3) ? 3 : 0;
            tbl[i].mh = (j >= 3) ? 2 : 0;
        end
        for (int i = 0; i < 24; i++) begin
            step(tbl[i].d, 1'b0);
            check($sformatf("vec%0d meas_valid", i), int'(meas_valid), int'(tbl[i].mv));
            check($sformatf("vec%0d locked", i), int'(locked), int'(tbl[i].lk));
            check($sformatf("vec%0d meas_period", i), int'(meas_period), tbl[i].mp);
            check($sformatf("vec%0d meas_high", i), int'(meas_high), tbl[i].mh);
        end

        // Long period while locked.
        clear_stats();
        period(4, 2);
        period(3, 2);
        check("long period err_period count", n_ep, 1);
        check("long period err_duty count", n_ed, 0);
        check("long period meas_period", last_mp, 4);
        check("long period locked drop", int'(locked), 0);
        repeat (3) period(3, 2);
        check("long period not yet relocked", int'(locked), 0);
        period(3, 2);
        check("long period relock", int'(locked), 1);

        // Short high time while locked.
        clear_stats();
        period(3, 1);
        period(3, 2);
        check("duty err_duty count", n_ed, 1);
        check("duty err_period count", n_ep, 0);
        check("duty meas_high", last_mh, 1);
        check("duty locked drop", int'(locked), 0);
        repeat (4) period(3, 2);
        check("duty relock", int'(locked), 1);

        // Loss of activity while locked.
        clear_stats();
        r0 = cyc;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        repeat (80) step(1'b0, 1'b0);
        check("timeout count", n_to, 1);
        check("timeout delay", t_to - r0, TMO + LAT);
        check("timeout no extra meas_valid", n_mv, 1);
        check("timeout locked", int'(locked), 0);
        repeat (4) period(3, 2);
        check("timeout no early relock", int'(locked), 0);
        period(3, 2);
        check("timeout relock", int'(locked), 1);

        // clr coincident with a detected rise while locked.
        clear_stats();
        for (int k = 0; k < 3; k++) step(k != 2, k == LAT);
        check("clr locked", int'(locked), 0);
        period(3, 2);
        check("clr meas_valid count", n_mv, 0);
        check("clr error count", n_ep + n_ed + n_to, 0);
        repeat (4) period(3, 2);
        check("clr relock", int'(locked), 1);

        // Asynchronous reset mid-period while locked.
        step(1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async reset");
        model_reset();
        @(posedge clk); #1;
        check_all_zero("held reset");
        rst_n = 1'b1;
        repeat (4) period(3, 2);
        check("post reset no early lock", int'(locked), 0);
        period(3, 2);
        check("post reset relock", int'(locked), 1);

        // Randomized traffic against the model.
        for (int it = 0; it < 80; it++) begin
            rr = $urandom_range(0, 9);
            if (rr < 5) begin
                period(DIV_N, EXP_HIGH);
            end else if (rr < 8) begin
                pr = $urandom_range(2, 6);
                hr = $urandom_range(1, pr - 1);
                period(pr, hr);
            end else if (rr == 8) begin
                ci = $urandom_range(0, 2);
                for (int k = 0; k < 3; k++) step(k != 2, k == ci);
            end else begin
                pr = $urandom_range(50, 90);
                hr = $urandom_range(0, 1);
                repeat (pr) step(hr[0], 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
